logic_unit_arbiter: RTL

- Shares one 32-bit bitwise logic datapath (AND/OR/XOR/NOR bit slices) between two requesters, port A and port B.
- In the core, port A is the execute stage and port B is the multdiv/aux sequencer.
- Arbitrates each cycle with round-robin fairness, drives the shared datapath, and returns results through per-port registered response slots using valid/ready handshakes.
- Also keeps a saturating contention counter for performance debug.

---
 rtl/logic_unit_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// Two-port round-robin arbiter in front of one shared 32-bit bitwise logic unit.
// Each port gets a registered one-deep response slot with valid/ready handshaking.
module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             a_req_valid,
  output logic             a_req_ready,
  input  logic [1:0]       a_op,
  input  logic [WIDTH-1:0] a_x,
  input  logic [WIDTH-1:0] a_y,
  output logic             a_rsp_valid,
  input  logic             a_rsp_ready,
  output logic [WIDTH-1:0] a_rsp_data,
  input  logic             b_req_valid,
  output logic             b_req_ready,
  input  logic [1:0]       b_op,
  input  logic [WIDTH-1:0] b_x,
  input  logic [WIDTH-1:0] b_y,
  output logic             b_rsp_valid,
  input  logic             b_rsp_ready,
  output logic [WIDTH-1:0] b_rsp_data,
  output logic             last_grant,
  output logic [CNT_W-1:0] contention_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [WIDTH-1:0] logic_fn(input logic [1:0] op,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = x & y;
      2'b01:   r = x | y;
      2'b10:   r = x ^ y;
      default: r = ~(x | y);
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

  logic             elig_a, elig_b;
  logic             grant_a, grant_b;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_x, sel_y, result;

  // A slot being drained this cycle can accept a new result at the same edge.
  assign elig_a  = a_req_valid & (~a_rsp_valid | a_rsp_ready);
  assign elig_b  = b_req_valid & (~b_rsp_valid | b_rsp_ready);
  assign grant_a = elig_a & (~elig_b | last_grant);
  assign grant_b = elig_b & (~elig_a | ~last_grant);

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;

  assign sel_op = grant_b ? b_op : a_op;
  assign sel_x  = grant_b ? b_x  : a_x;
  assign sel_y  = grant_b ? b_y  : a_y;
  assign result = logic_fn(sel_op, sel_x, sel_y);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_rsp_valid    <= 1'b0;
      a_rsp_data     <= '0;
      b_rsp_valid    <= 1'b0;
      b_rsp_data     <= '0;
      last_grant     <= 1'b1;
      contention_cnt <= '0;
    end else begin
      if (grant_a) begin
        a_rsp_valid <= 1'b1;
        a_rsp_data  <= result;
      end else if (a_rsp_ready) begin
        a_rsp_valid <= 1'b0;
      end
      if (grant_b) begin
        b_rsp_valid <= 1'b1;
        b_rsp_data  <= result;
      end else if (b_rsp_ready) begin
        b_rsp_valid <= 1'b0;
      end
      if (grant_a)
        last_grant <= 1'b0;
      else if (grant_b)
        last_grant <= 1'b1;
      if (elig_a & elig_b)
        contention_cnt <= sat_inc(contention_cnt);
    end
  end

endmodule
